multi_key_repeat_debounce: RTL and testbench

//  N-channel switch/button front end, the parametrised successor of the single-input debouncer.
//  Per channel: 2-FF synchroniser, symmetric stable-time debounce for both press and release,
//  and one-cycle press, release and auto-repeat event pulses.

---
 rtl/multi_key_repeat_debounce.sv | 142 ++++++++++++++
 tb/tb_multi_key_repeat_debounce.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_key_repeat_debounce.sv
// N-channel key front end: 2-FF sync, symmetric debounce, press/release/auto-repeat pulses.
// Latency: noisy edge to clean and its pulse is 2+STABLE_CYCLES clocks; no backpressure, pulses are fire-and-forget.
// Define DEBOUNCE_ACCEL_EN to halve the repeat period on each repeat down to REPEAT_INIT>>MAX_HALVINGS.
module multi_key_repeat_debounce #(
  parameter int N_KEYS        = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int REPEAT_INIT   = 100000000,
  parameter int MAX_HALVINGS  = 7,
  parameter int CNT_W         = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] noisy,
  output logic [N_KEYS-1:0] clean,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  localparam int STEP_W = (MAX_HALVINGS < 2) ? 1 : $clog2(MAX_HALVINGS + 1);

`ifdef DEBOUNCE_ACCEL_EN
  localparam int FLOOR_PERIOD = REPEAT_INIT >> MAX_HALVINGS;
`else
  localparam int FLOOR_PERIOD = REPEAT_INIT;
`endif

  if (FLOOR_PERIOD < 2) begin : g_floor_chk
    $error("repeat floor period must be at least 2 cycles");
  end
  if (MAX_HALVINGS < 0) begin : g_halv_chk
    $error("MAX_HALVINGS must be non-negative");
  end
  if (STABLE_CYCLES < 1) begin : g_stable_chk
    $error("STABLE_CYCLES must be at least 1");
  end
  if ((longint'(REPEAT_INIT) >= (longint'(1) << CNT_W)) ||
      (longint'(STABLE_CYCLES) >= (longint'(1) << CNT_W))) begin : g_width_chk
    $error("CNT_W too narrow for REPEAT_INIT or STABLE_CYCLES");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic [1:0]       sync_ff;
    logic             sync;
    logic [CNT_W-1:0] deb_cnt;
    logic             clean_r;
    logic             press_r;
    logic             rel_r;
    logic             rep_r;
    logic [1:0]       state;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] period;
    logic             accept;
    logic             rise;
    logic             fall;
    logic             rep_hit;

`ifdef DEBOUNCE_ACCEL_EN
    logic [STEP_W-1:0] step;
`else
    assign period = CNT_W'(REPEAT_INIT);
`endif

    assign sync    = sync_ff[1];
    assign accept  = (sync != clean_r) && (deb_cnt == CNT_W'(STABLE_CYCLES - 1));
    assign rise    = accept & sync;
    assign fall    = accept & ~sync;
    assign rep_hit = (rep_cnt == period - CNT_W'(1));

    // The repeat FSM acts on the accept decision so its counter starts with clean.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_ff <= 2'b00;
        deb_cnt <= '0;
        clean_r <= 1'b0;
        press_r <= 1'b0;
        rel_r   <= 1'b0;
        rep_r   <= 1'b0;
        state   <= IDLE;
        rep_cnt <= '0;
`ifdef DEBOUNCE_ACCEL_EN
        period  <= CNT_W'(REPEAT_INIT);
        step    <= '0;
`endif
      end else begin
        sync_ff <= {sync_ff[0], noisy[i]};
        press_r <= rise;
        rel_r   <= fall;
        rep_r   <= 1'b0;

        if (sync == clean_r) begin
          deb_cnt <= '0;
        end else if (accept) begin
          clean_r <= sync;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end

        if (fall) begin
          state   <= IDLE;
          rep_cnt <= '0;
`ifdef DEBOUNCE_ACCEL_EN
          period  <= CNT_W'(REPEAT_INIT);
          step    <= '0;
`endif
        end else if (rise) begin
          state   <= HOLD;
          rep_cnt <= '0;
`ifdef DEBOUNCE_ACCEL_EN
          period  <= CNT_W'(REPEAT_INIT);
          step    <= '0;
`endif
        end else if (state != IDLE) begin
          if (rep_hit) begin
            rep_r   <= 1'b1;
            rep_cnt <= '0;
            state   <= REPEAT;
`ifdef DEBOUNCE_ACCEL_EN
            if (step < STEP_W'(MAX_HALVINGS)) begin
              period <= period >> 1;
              step   <= step + STEP_W'(1);
            end
`endif
          end else begin
            rep_cnt <= rep_cnt + CNT_W'(1);
          end
        end
      end
    end

    assign clean[i]         = clean_r;
    assign press_pulse[i]   = press_r;
    assign release_pulse[i] = rel_r;
    assign repeat_pulse[i]  = rep_r;
  end

endmodule

// File: tb/tb_multi_key_repeat_debounce.sv
// Scoreboard bench for multi_key_repeat_debounce with N_KEYS=2, STABLE_CYCLES=4, REPEAT_INIT=16, MAX_HALVINGS=2.
// Cycle label c is the sample taken after the c-th rising edge following the first edge that samples the stimulus.
module tb_multi_key_repeat_debounce;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_REP   = 2;
`ifdef DEBOUNCE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  typedef struct {
    int         cyc;
    int         kind;
    logic [1:0] mask;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] noisy = 2'b00;
  logic [1:0] clean, press_pulse, release_pulse, repeat_pulse;

  ev_t        sb[$];
  int         cyc;
  int         total = 0;
  int         bad = 0;
  logic [1:0] exp_press, exp_rel, exp_rep, exp_clean;

  multi_key_repeat_debounce #(
    .N_KEYS(2), .STABLE_CYCLES(4), .REPEAT_INIT(16), .MAX_HALVINGS(2), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .noisy(noisy), .clean(clean),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic push_ev(input int c, input int k, input logic [1:0] m);
    ev_t e;
    e.cyc = c; e.kind = k; e.mask = m;
    sb.push_back(e);
  endtask

  // Expected repeat times for a key pressed at label p, up to and including label last.
  task automatic push_repeats(input int p, input int last, input logic [1:0] m);
    int period;
    int st;
    int t;
    period = 16; st = 0; t = p + 16;
    while (t <= last) begin
      push_ev(t, K_REP, m);
      if (ACCEL && st < 2) begin
        period = period / 2;
        st++;
      end
      t += period;
    end
  endtask

  // Advance one clock and pop the expectations due in the new cycle.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    exp_press = 2'b00; exp_rel = 2'b00; exp_rep = 2'b00;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].cyc == cyc) begin
        case (sb[j].kind)
          K_PRESS: exp_press |= sb[j].mask;
          K_REL:   exp_rel   |= sb[j].mask;
          default: exp_rep   |= sb[j].mask;
        endcase
        sb.delete(j);
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    noisy = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    noisy = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({clean, press_pulse, release_pulse, repeat_pulse} !== 8'h00) begin
      bad++;
      $display("FAIL reset_state got=%b want=00000000", {clean, press_pulse, release_pulse, repeat_pulse});
    end
    reset = 1'b0;
    sb.delete();
    cyc = 0;
    noisy = 2'b11;
    push_ev(6, K_PRESS, 2'b11);
    while (cyc < 10) begin
      step();
      exp_clean = (cyc >= 6) ? 2'b11 : 2'b00;
      total += 4;
      if (press_pulse !== exp_press) begin bad++; $display("FAIL reset_press cyc=%0d got=%b want=%b", cyc, press_pulse, exp_press); end
      if (release_pulse !== exp_rel) begin bad++; $display("FAIL reset_release cyc=%0d got=%b want=%b", cyc, release_pulse, exp_rel); end
      if (repeat_pulse !== exp_rep) begin bad++; $display("FAIL reset_repeat cyc=%0d got=%b want=%b", cyc, repeat_pulse, exp_rep); end
      if (clean !== exp_clean) begin bad++; $display("FAIL reset_clean cyc=%0d got=%b want=%b", cyc, clean, exp_clean); end
    end
    // Asynchronous abort mid-hold: outputs clear without waiting for a clock edge.
    reset = 1'b1;
    #1;
    total++;
    if ({clean, press_pulse, release_pulse, repeat_pulse} !== 8'h00) begin
      bad++;
      $display("FAIL reset_async got=%b want=00000000", {clean, press_pulse, release_pulse, repeat_pulse});
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    cyc = 0;
    push_ev(6, K_PRESS, 2'b11);
    while (cyc < 8) begin
      step();
      exp_clean = (cyc >= 6) ? 2'b11 : 2'b00;
      total += 2;
      if (press_pulse !== exp_press) begin bad++; $display("FAIL rearm_press cyc=%0d got=%b want=%b", cyc, press_pulse, exp_press); end
      if (clean !== exp_clean) begin bad++; $display("FAIL rearm_clean cyc=%0d got=%b want=%b", cyc, clean, exp_clean); end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL reset_leftover got=%0d want=0", sb.size()); end
  endtask

  task automatic test_glitch();
    for (int len = 3; len <= 4; len++) begin
      apply_reset();
      if (len == 4) begin
        push_ev(6, K_PRESS, 2'b01);
        push_ev(10, K_REL, 2'b01);
      end
      noisy = 2'b01;
      while (cyc < 20) begin
        if (cyc == len) noisy = 2'b00;
        step();
        exp_clean = (len == 4 && cyc >= 6 && cyc < 10) ? 2'b01 : 2'b00;
        total += 4;
        if (press_pulse !== exp_press) begin bad++; $display("FAIL glitch%0d_press cyc=%0d got=%b want=%b", len, cyc, press_pulse, exp_press); end
        if (release_pulse !== exp_rel) begin bad++; $display("FAIL glitch%0d_release cyc=%0d got=%b want=%b", len, cyc, release_pulse, exp_rel); end
        if (repeat_pulse !== exp_rep) begin bad++; $display("FAIL glitch%0d_repeat cyc=%0d got=%b want=%b", len, cyc, repeat_pulse, exp_rep); end
        if (clean !== exp_clean) begin bad++; $display("FAIL glitch%0d_clean cyc=%0d got=%b want=%b", len, cyc, clean, exp_clean); end
      end
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL glitch%0d_leftover got=%0d want=0", len, sb.size()); end
    end
  endtask

  task automatic test_repeat();
    apply_reset();
    push_ev(6, K_PRESS, 2'b01);
    push_repeats(6, 38, 2'b01);
    push_ev(39, K_REL, 2'b01);
    push_ev(51, K_PRESS, 2'b01);
    push_repeats(51, 80, 2'b01);
    noisy = 2'b01;
    while (cyc < 80) begin
      if (cyc == 33) noisy = 2'b00;
      if (cyc == 45) noisy = 2'b01;
      step();
      exp_clean = ((cyc >= 6 && cyc < 39) || cyc >= 51) ? 2'b01 : 2'b00;
      total += 4;
      if (press_pulse !== exp_press) begin bad++; $display("FAIL repeat_press cyc=%0d got=%b want=%b", cyc, press_pulse, exp_press); end
      if (release_pulse !== exp_rel) begin bad++; $display("FAIL repeat_release cyc=%0d got=%b want=%b", cyc, release_pulse, exp_rel); end
      if (repeat_pulse !== exp_rep) begin bad++; $display("FAIL repeat_repeat cyc=%0d got=%b want=%b", cyc, repeat_pulse, exp_rep); end
      if (clean !== exp_clean) begin bad++; $display("FAIL repeat_clean cyc=%0d got=%b want=%b", cyc, clean, exp_clean); end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL repeat_leftover got=%0d want=0", sb.size()); end
  endtask

  task automatic test_independent();
    apply_reset();
    push_ev(6, K_PRESS, 2'b11);
    push_repeats(6, 60, 2'b01);
    push_ev(16, K_REL, 2'b10);
    push_ev(26, K_PRESS, 2'b10);
    push_repeats(26, 60, 2'b10);
    noisy = 2'b11;
    while (cyc < 60) begin
      if (cyc == 10) noisy = 2'b01;
      if (cyc == 20) noisy = 2'b11;
      step();
      exp_clean[0] = (cyc >= 6);
      exp_clean[1] = (cyc >= 6 && cyc < 16) || cyc >= 26;
      total += 4;
      if (press_pulse !== exp_press) begin bad++; $display("FAIL indep_press cyc=%0d got=%b want=%b", cyc, press_pulse, exp_press); end
      if (release_pulse !== exp_rel) begin bad++; $display("FAIL indep_release cyc=%0d got=%b want=%b", cyc, release_pulse, exp_rel); end
      if (repeat_pulse !== exp_rep) begin bad++; $display("FAIL indep_repeat cyc=%0d got=%b want=%b", cyc, repeat_pulse, exp_rep); end
      if (clean !== exp_clean) begin bad++; $display("FAIL indep_clean cyc=%0d got=%b want=%b", cyc, clean, exp_clean); end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL indep_leftover got=%0d want=0", sb.size()); end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_glitch();
    test_repeat();
    test_independent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
